// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - Shared constants and types for the SPI peripheral.
package spi_pkg;

    localparam int SPI_DEFAULT_WIDTH = 8;

    typedef enum logic {
        SPI_LSB_FIRST = 1'b0,
        SPI_MSB_FIRST = 1'b1
    } spi_order_e;

endpackage

// File: rtl/spi_shift_reg.sv
// rtl/spi_shift_reg.sv - Parametrised full-duplex SPI shift register with bit counter,
// stable received-word register and one-cycle completion strobe.
module spi_shift_reg
    import spi_pkg::*;
#(
    parameter int         WIDTH     = SPI_DEFAULT_WIDTH,
    parameter spi_order_e MSB_FIRST = SPI_MSB_FIRST,
    parameter int         CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             shift_i,
    input  logic             miso_i,
    output logic             mosi_o,
    output logic [WIDTH-1:0] out_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;

    // The received bit always enters at the end opposite to the bit being driven out.
    generate
        if (MSB_FIRST == SPI_MSB_FIRST) begin : g_msb_first
            assign sr_next = {sr[WIDTH-2:0], miso_i};
            assign mosi_o  = sr[WIDTH-1];
        end else begin : g_lsb_first
            assign sr_next = {miso_i, sr[WIDTH-1:1]};
            assign mosi_o  = sr[0];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sr     <= '0;
            out_o  <= '0;
            cnt_o  <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (load_i) begin
                // A load also aborts any frame in flight; out_o is left untouched.
                sr     <= data_i;
                cnt_o  <= '0;
                busy_o <= 1'b1;
            end else if (shift_i && busy_o) begin
                sr <= sr_next;
                if (cnt_o == LAST_BIT) begin
                    out_o  <= sr_next;
                    cnt_o  <= '0;
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                end else begin
                    cnt_o <= cnt_o + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_shift_reg.sv
// tb/tb_spi_shift_reg.sv - Directed bench for spi_shift_reg: 8-bit MSB/LSB-first
// instances driven from a vector table, 16-bit back-to-back frame by hand.
`timescale 1ns/1ps
module tb_spi_shift_reg;
    import spi_pkg::*;

    logic clk_i = 1'b0;
    always #50 clk_i = ~clk_i;

    logic       a_rst = 1'b1, a_load = 1'b0, a_shift = 1'b0, a_miso = 1'b0;
    logic [7:0] a_data = '0;
    logic       a_mosi, a_busy, a_done;
    logic [7:0] a_out;
    logic [3:0] a_cnt;

    logic       b_rst = 1'b1, b_load = 1'b0, b_shift = 1'b0, b_miso = 1'b0;
    logic [7:0] b_data = '0;
    logic       b_mosi, b_busy, b_done;
    logic [7:0] b_out;
    logic [3:0] b_cnt;

    logic        c_rst = 1'b1, c_load = 1'b0, c_shift = 1'b0, c_miso = 1'b0;
    logic [15:0] c_data = '0;
    logic        c_mosi, c_busy, c_done;
    logic [15:0] c_out;
    logic [4:0]  c_cnt;

    spi_shift_reg #(.WIDTH(8), .MSB_FIRST(SPI_MSB_FIRST)) dut_a (
        .clk_i(clk_i), .reset_i(a_rst), .load_i(a_load), .data_i(a_data),
        .shift_i(a_shift), .miso_i(a_miso), .mosi_o(a_mosi), .out_o(a_out),
        .busy_o(a_busy), .done_o(a_done), .cnt_o(a_cnt));

    spi_shift_reg #(.WIDTH(8), .MSB_FIRST(SPI_LSB_FIRST)) dut_b (
        .clk_i(clk_i), .reset_i(b_rst), .load_i(b_load), .data_i(b_data),
        .shift_i(b_shift), .miso_i(b_miso), .mosi_o(b_mosi), .out_o(b_out),
        .busy_o(b_busy), .done_o(b_done), .cnt_o(b_cnt));

    spi_shift_reg #(.WIDTH(16), .MSB_FIRST(SPI_MSB_FIRST)) dut_c (
        .clk_i(clk_i), .reset_i(c_rst), .load_i(c_load), .data_i(c_data),
        .shift_i(c_shift), .miso_i(c_miso), .mosi_o(c_mosi), .out_o(c_out),
        .busy_o(c_busy), .done_o(c_done), .cnt_o(c_cnt));

    typedef struct {
        logic       sel;
        logic       rst;
        logic       load;
        logic [7:0] data;
        logic       shift;
        logic       miso;
        logic       exp_mosi;
        logic       exp_done;
        logic       exp_busy;
        logic [3:0] exp_cnt;
        logic [7:0] exp_out;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic sel, input logic rst, input logic load, input logic [7:0] data,
                       input logic shift, input logic miso, input logic mosi, input logic done,
                       input logic busy, input logic [3:0] cnt, input logic [7:0] out);
        vec_t v;
        v.sel = sel; v.rst = rst; v.load = load; v.data = data; v.shift = shift; v.miso = miso;
        v.exp_mosi = mosi; v.exp_done = done; v.exp_busy = busy; v.exp_cnt = cnt; v.exp_out = out;
        tbl.push_back(v);
    endtask

    initial begin
        logic [15:0] rx;

        // Test 1: MSB first, tx 0xA5, rx 0x3C
        add(0,0,1,8'hA5,0,0, 1,0,1,0,8'h00);
        add(0,0,0,8'h00,1,0, 0,0,1,1,8'h00);
        add(0,0,0,8'h00,1,0, 1,0,1,2,8'h00);
        add(0,0,0,8'h00,1,1, 0,0,1,3,8'h00);
        add(0,0,0,8'h00,1,1, 0,0,1,4,8'h00);
        add(0,0,0,8'h00,1,1, 1,0,1,5,8'h00);
        add(0,0,0,8'h00,1,1, 0,0,1,6,8'h00);
        add(0,0,0,8'h00,1,0, 1,0,1,7,8'h00);
        add(0,0,0,8'h00,1,0, 0,1,0,0,8'h3C);
        add(0,0,0,8'h00,0,0, 0,0,0,0,8'h3C);
        // Test 3: abort after 3 shifts, then full frame of ones
        add(0,0,1,8'hFF,0,0, 1,0,1,0,8'h3C);
        add(0,0,0,8'h00,1,0, 1,0,1,1,8'h3C);
        add(0,0,0,8'h00,1,0, 1,0,1,2,8'h3C);
        add(0,0,0,8'h00,1,0, 1,0,1,3,8'h3C);
        add(0,0,1,8'h00,0,0, 0,0,1,0,8'h3C);
        for (int k = 1; k <= 7; k++) add(0,0,0,8'h00,1,1, 0,0,1,4'(k),8'h3C);
        add(0,0,0,8'h00,1,1, 1,1,0,0,8'hFF);
        add(0,0,0,8'h00,0,0, 1,0,0,0,8'hFF);
        // Test 4: load+shift together, frame rx 0xA6, then idle shift
        add(0,0,1,8'h80,1,1, 1,0,1,0,8'hFF);
        add(0,0,0,8'h00,1,1, 0,0,1,1,8'hFF);
        add(0,0,0,8'h00,1,0, 0,0,1,2,8'hFF);
        add(0,0,0,8'h00,1,1, 0,0,1,3,8'hFF);
        add(0,0,0,8'h00,1,0, 0,0,1,4,8'hFF);
        add(0,0,0,8'h00,1,0, 0,0,1,5,8'hFF);
        add(0,0,0,8'h00,1,1, 0,0,1,6,8'hFF);
        add(0,0,0,8'h00,1,1, 0,0,1,7,8'hFF);
        add(0,0,0,8'h00,1,0, 1,1,0,0,8'hA6);
        add(0,0,0,8'h00,1,1, 1,0,0,0,8'hA6);
        // Test 5: reset mid-frame
        add(0,0,1,8'h55,0,0, 0,0,1,0,8'hA6);
        add(0,0,0,8'h00,1,0, 1,0,1,1,8'hA6);
        add(0,0,0,8'h00,1,0, 0,0,1,2,8'hA6);
        add(0,0,0,8'h00,1,0, 1,0,1,3,8'hA6);
        add(0,0,0,8'h00,1,0, 0,0,1,4,8'hA6);
        add(0,1,0,8'h00,0,0, 0,0,0,0,8'h00);
        add(0,0,0,8'h00,0,0, 0,0,0,0,8'h00);
        // Test 2: LSB first, tx 0x0F, rx 0xC3
        add(1,0,1,8'h0F,0,0, 1,0,1,0,8'h00);
        add(1,0,0,8'h00,1,1, 1,0,1,1,8'h00);
        add(1,0,0,8'h00,1,1, 1,0,1,2,8'h00);
        add(1,0,0,8'h00,1,0, 1,0,1,3,8'h00);
        add(1,0,0,8'h00,1,0, 0,0,1,4,8'h00);
        add(1,0,0,8'h00,1,0, 0,0,1,5,8'h00);
        add(1,0,0,8'h00,1,0, 0,0,1,6,8'h00);
        add(1,0,0,8'h00,1,1, 0,0,1,7,8'h00);
        add(1,0,0,8'h00,1,1, 1,1,0,0,8'hC3);
        add(1,0,0,8'h00,0,0, 1,0,0,0,8'hC3);

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        chk("reset_a_state", {a_mosi, a_done, a_busy, a_cnt, a_out}, '0);
        chk("reset_b_state", {b_mosi, b_done, b_busy, b_cnt, b_out}, '0);
        chk("reset_c_state", {c_mosi, c_done, c_busy, c_cnt, c_out}, '0);

        foreach (tbl[i]) begin
            @(negedge clk_i);
            a_rst = 0; a_load = 0; a_data = '0; a_shift = 0; a_miso = 0;
            b_rst = 0; b_load = 0; b_data = '0; b_shift = 0; b_miso = 0;
            if (tbl[i].sel == 1'b0) begin
                a_rst = tbl[i].rst; a_load = tbl[i].load; a_data = tbl[i].data;
                a_shift = tbl[i].shift; a_miso = tbl[i].miso;
            end else begin
                b_rst = tbl[i].rst; b_load = tbl[i].load; b_data = tbl[i].data;
                b_shift = tbl[i].shift; b_miso = tbl[i].miso;
            end
            @(posedge clk_i);
            #1;
            if (tbl[i].sel == 1'b0) begin
                chk($sformatf("vec%0d_mosi", i), 32'(a_mosi), 32'(tbl[i].exp_mosi));
                chk($sformatf("vec%0d_done", i), 32'(a_done), 32'(tbl[i].exp_done));
                chk($sformatf("vec%0d_busy", i), 32'(a_busy), 32'(tbl[i].exp_busy));
                chk($sformatf("vec%0d_cnt", i),  32'(a_cnt),  32'(tbl[i].exp_cnt));
                chk($sformatf("vec%0d_out", i),  32'(a_out),  32'(tbl[i].exp_out));
            end else begin
                chk($sformatf("vec%0d_mosi", i), 32'(b_mosi), 32'(tbl[i].exp_mosi));
                chk($sformatf("vec%0d_done", i), 32'(b_done), 32'(tbl[i].exp_done));
                chk($sformatf("vec%0d_busy", i), 32'(b_busy), 32'(tbl[i].exp_busy));
                chk($sformatf("vec%0d_cnt", i),  32'(b_cnt),  32'(tbl[i].exp_cnt));
                chk($sformatf("vec%0d_out", i),  32'(b_out),  32'(tbl[i].exp_out));
            end
        end
        @(negedge clk_i);
        a_load = 0; a_shift = 0; b_load = 0; b_shift = 0;

        // Test 6: 16-bit frame receiving 0xBEEF, next frame loaded in the done cycle
        rx = 16'hBEEF;
        c_load = 1'b1; c_data = 16'h0000;
        @(posedge clk_i); #1;
        chk("w16_load_busy", 32'(c_busy), 32'd1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_i);
            c_load = 1'b0; c_shift = 1'b1; c_miso = rx[15-i];
            @(posedge clk_i); #1;
            if (i < 15) begin
                chk($sformatf("w16_cnt%0d", i), 32'(c_cnt), 32'(i + 1));
                chk($sformatf("w16_nodone%0d", i), 32'(c_done), 32'd0);
            end else begin
                chk("w16_done", 32'(c_done), 32'd1);
                chk("w16_out", 32'(c_out), 32'hBEEF);
                chk("w16_cnt_clr", 32'(c_cnt), 32'd0);
                chk("w16_idle", 32'(c_busy), 32'd0);
            end
        end
        @(negedge clk_i);
        c_shift = 1'b0; c_load = 1'b1; c_data = 16'h1234;
        @(posedge clk_i); #1;
        chk("b2b_busy", 32'(c_busy), 32'd1);
        chk("b2b_out", 32'(c_out), 32'hBEEF);
        chk("b2b_done_clr", 32'(c_done), 32'd0);
        chk("b2b_mosi", 32'(c_mosi), 32'd0);
        @(negedge clk_i);
        c_load = 1'b0;
        @(posedge clk_i); #1;
        chk("b2b_hold_busy", 32'(c_busy), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_shift_reg.md
Name: spi_shift_reg

Overview:
- Parametrised full-duplex shift register for the SPI peripheral. It replaces the fixed 8-bit serial-in/parallel-out receive register.
- It loads a transmit word in parallel and drives MOSI serially while capturing MISO.
- It counts bits and presents the received word on a stable parallel output, with a one-cycle completion strobe.
- It sits between the SPI control FSM (which generates load/shift strobes from SCLK edges) and the peripheral register interface.

Parameters:
- WIDTH, 8, frame length in bits; legal range 2..32.
- MSB_FIRST, 1, bit order: 1 = MSB first on both MOSI and MISO; 0 = LSB first.
- CNT_W, $clog2(WIDTH+1), width of the bit counter (derived; do not override).

Ports:
- clk_i  in  1  system clock, 10 MHz.
- reset_i  in  1  synchronous reset, active-high.
- load_i  in  1  one-cycle strobe: load data_i and start a frame.
- data_i  in  WIDTH  transmit word.
- shift_i  in  1  one-cycle strobe: shift one bit (one SCLK sample edge).
- miso_i  in  1  serial input from the slave.
- mosi_o  out  1  serial output to the slave.
- out_o  out  WIDTH  last completed received word.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle pulse: frame completed, out_o just updated.
- cnt_o  out  CNT_W  bits shifted in the current frame.

Behaviour:
- Reset: reset_i is sampled on posedge clk_i and has priority over every other input. It sets sr=0, out_o=0, cnt_o=0, busy_o=0, done_o=0, so mosi_o=0.
- Internal state: WIDTH-bit register sr; counter cnt; flag busy.
- mosi_o is combinational from sr: sr[WIDTH-1] if MSB_FIRST, else sr[0]. The first bit is valid in the cycle after load_i.
- load_i (no reset):
  - sr<=data_i, cnt<=0, busy<=1, done<=0.
  - load_i has priority over a simultaneous shift_i; that shift is dropped.
  - load_i while busy aborts the current frame: out_o is unchanged and no done_o pulse is issued.
- shift_i while busy (no load_i):
  - MSB_FIRST=1: sr<={sr[WIDTH-2:0], miso_i}.
  - MSB_FIRST=0: sr<={miso_i, sr[WIDTH-1:1]}.
  - cnt<=cnt+1.
- Completion: shift_i arrives while busy and cnt==WIDTH-1.
  - out_o<=the shifted value, i.e. the received word in natural bit order.
  - busy<=0, cnt<=0, done_o<=1 for exactly one cycle.
  - done_o is registered: it is high in the cycle after the WIDTH-th shift edge, coincident with the new out_o.
- shift_i while idle is ignored: sr, cnt and out_o hold, and mosi_o holds the last sr bit.
- done_o is cleared in every cycle that does not complete a frame.
- out_o changes only at completion or reset. It is never a partial word.
- cnt never exceeds WIDTH-1 during a frame and never wraps.
- Back-to-back frames: load_i is accepted in the same cycle done_o is high; busy_o goes high again the following cycle.
- Reset mid-frame: everything returns to reset values, with no done_o pulse.

Decomposition:
- Package spi_pkg:
  - localparam SPI_DEFAULT_WIDTH=8.
  - typedef enum logic {SPI_LSB_FIRST=0, SPI_MSB_FIRST=1} spi_order_e, used for the MSB_FIRST parameter.
- Single flat module; no sub-module is needed. Counter, shift path and output register all fit in one always_ff plus the mosi_o assign.

Test Plan:
1. WIDTH=8, MSB_FIRST=1:
   - Stimulus: load 0xA5, then 8 shifts with miso bits of 0x3C sent MSB first (0,0,1,1,1,1,0,0).
   - Response: mosi_o before each shift = 1,0,1,0,0,1,0,1; out_o=0x3C with done_o high exactly one cycle after the 8th shift; busy_o=0.
2. WIDTH=8, MSB_FIRST=0:
   - Stimulus: load 0x0F, 8 shifts with miso = 0xC3 sent LSB first (1,1,0,0,0,0,1,1).
   - Response: mosi_o = 1,1,1,1,0,0,0,0; out_o=0xC3; done_o single pulse.
3. Abort:
   - Stimulus: after test 1, load 0xFF and shift 3 times, then load 0x00 and complete 8 shifts of miso=1.
   - Response: no done_o after the abort; out_o stays 0x3C until the final completion, then becomes 0xFF.
4. Priority and idle:
   - Stimulus: assert load_i and shift_i together with data 0x80; then shift_i while idle after a completed frame.
   - Response: cnt_o=0 after the simultaneous cycle and mosi_o=1; the idle shift leaves out_o and cnt_o unchanged, with done_o=0.
5. Reset mid-frame:
   - Stimulus: load 0x55, shift 4 times, then pulse reset_i for 1 cycle.
   - Response: out_o=0, cnt_o=0, busy_o=0, mosi_o=0, done_o never asserted.
6. WIDTH=16, MSB_FIRST=1:
   - Stimulus: back-to-back frames, load 0x1234 in the done_o cycle of a frame receiving 0xBEEF.
   - Response: out_o=0xBEEF and busy_o=1 on the next cycle; cnt_o reaches 15 and then clears to 0.
